// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite master: turns one valid/ready command into one
// AXI4-Lite read or write and returns the data/response on a valid/ready port.
module axi4_lite_master #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDRESS_WIDTH-1:0]  cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic [ADDRESS_WIDTH-1:0]  M_AXI_ARADDR,
  output logic                      M_AXI_ARVALID,
  input  logic                      M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                M_AXI_RRESP,
  input  logic                      M_AXI_RVALID,
  output logic                      M_AXI_RREADY,
  output logic [ADDRESS_WIDTH-1:0]  M_AXI_AWADDR,
  output logic                      M_AXI_AWVALID,
  input  logic                      M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                      M_AXI_WVALID,
  input  logic                      M_AXI_WREADY,
  input  logic [1:0]                M_AXI_BRESP,
  input  logic                      M_AXI_BVALID,
  output logic                      M_AXI_BREADY,
  output logic [2:0]                dbg_state
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RADDR = 3'd1,
    RDATA = 3'd2,
    WRITE = 3'd3,
    WRESP = 3'd4,
    RSP   = 3'd5
  } state_t;

  state_t                    state, state_d;
  logic [ADDRESS_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]     wstrb_q, wstrb_d;
  logic [DATA_WIDTH-1:0]     rdata_d;
  logic [1:0]                resp_d;
  logic                      rsp_valid_d;
  logic                      arvalid_d, rready_d, awvalid_d, wvalid_d, bready_d;
  logic                      aw_done, aw_done_d, w_done, w_done_d;

  // Handshake rule on every channel: a transfer happens on the rising edge
  // where VALID and READY are both high; VALID never drops before that edge
  // and the payload is held constant from VALID rising until the transfer.
  assign cmd_ready     = (state == IDLE) && ARESETN;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign dbg_state     = state;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state         <= IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      rsp_rdata     <= '0;
      rsp_resp      <= '0;
      rsp_valid     <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
    end else begin
      state         <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      rsp_rdata     <= rdata_d;
      rsp_resp      <= resp_d;
      rsp_valid     <= rsp_valid_d;
      M_AXI_ARVALID <= arvalid_d;
      M_AXI_RREADY  <= rready_d;
      M_AXI_AWVALID <= awvalid_d;
      M_AXI_WVALID  <= wvalid_d;
      M_AXI_BREADY  <= bready_d;
      aw_done       <= aw_done_d;
      w_done        <= w_done_d;
    end
  end

  always_comb begin
    state_d     = state;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rdata_d     = rsp_rdata;
    resp_d      = rsp_resp;
    rsp_valid_d = rsp_valid;
    arvalid_d   = M_AXI_ARVALID;
    rready_d    = M_AXI_RREADY;
    awvalid_d   = M_AXI_AWVALID;
    wvalid_d    = M_AXI_WVALID;
    bready_d    = M_AXI_BREADY;
    aw_done_d   = aw_done;
    w_done_d    = w_done;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          if (cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WRITE;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RADDR;
          end
        end
      end
      RADDR: begin
        if (M_AXI_ARVALID && M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RDATA;
        end
      end
      RDATA: begin
        if (M_AXI_RVALID) begin
          rready_d    = 1'b0;
          rdata_d     = M_AXI_RDATA;
          resp_d      = M_AXI_RRESP;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end
      WRITE: begin
        // AW and W retire independently; whichever finishes first waits for the other.
        if (M_AXI_AWVALID && M_AXI_AWREADY) begin
          aw_done_d = 1'b1;
          awvalid_d = 1'b0;
        end
        if (M_AXI_WVALID && M_AXI_WREADY) begin
          w_done_d = 1'b1;
          wvalid_d = 1'b0;
        end
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          bready_d  = 1'b1;
          state_d   = WRESP;
        end
      end
      WRESP: begin
        if (M_AXI_BVALID) begin
          bready_d    = 1'b0;
          rdata_d     = '0;
          resp_d      = M_AXI_BRESP;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi4_lite_master.sv
// Directed bench for axi4_lite_master: a cycle-stepped slave memory with
// per-channel ready delays, driven and checked from one linear initial block.
module tb_axi4_lite_master;

  logic        clk;
  logic        ARESETN;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] M_AXI_ARADDR, M_AXI_RDATA, M_AXI_AWADDR, M_AXI_WDATA;
  logic        M_AXI_ARVALID, M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RREADY;
  logic [1:0]  M_AXI_RRESP, M_AXI_BRESP;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_BVALID, M_AXI_BREADY;
  logic [2:0]  dbg_state;

  logic [31:0] mem [0:15];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          acc_cyc  = 0;
  int          lat      = 0;
  int          aw_hs_c  = -1;
  int          w_hs_c   = -1;

  axi4_lite_master #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
    .ACLK(clk), .ARESETN(ARESETN),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
    .M_AXI_RREADY(M_AXI_RREADY),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
    .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .dbg_state(dbg_state)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_rsp_resp"}, 32'(rsp_resp), 0);
    chk({tag, "_araddr"}, M_AXI_ARADDR, 0);
    chk({tag, "_arvalid"}, 32'(M_AXI_ARVALID), 0);
    chk({tag, "_rready"}, 32'(M_AXI_RREADY), 0);
    chk({tag, "_awaddr"}, M_AXI_AWADDR, 0);
    chk({tag, "_awvalid"}, 32'(M_AXI_AWVALID), 0);
    chk({tag, "_wdata"}, M_AXI_WDATA, 0);
    chk({tag, "_wstrb"}, 32'(M_AXI_WSTRB), 0);
    chk({tag, "_wvalid"}, 32'(M_AXI_WVALID), 0);
    chk({tag, "_bready"}, 32'(M_AXI_BREADY), 0);
    chk({tag, "_state"}, 32'(dbg_state), 0);
  endtask

  // Driver: called and returns on a falling edge; returns in the cycle after accept.
  task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_wstrb = strb;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept", 32'(cmd_ready), 1);
    acc_cyc = cyc;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_wdata = '0;
    cmd_wstrb = '0;
    chk("cmd_ready_busy", 32'(cmd_ready), 0);
  endtask

  // Slave write side: AWREADY/WREADY offered aw_dly/w_dly cycles after VALID first seen.
  task automatic slave_write(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input logic [1:0] bresp);
    bit aw_seen, w_seen, b_done, aw_hs, w_hs, b_hs;
    logic [31:0] cap_addr, cap_data;
    logic [3:0]  cap_strb;
    int c;
    aw_seen = 0; w_seen = 0; b_done = 0; c = 0;
    cap_addr = '0; cap_data = '0; cap_strb = '0;
    forever begin
      chk("awvalid", 32'(M_AXI_AWVALID), 32'(!aw_seen));
      chk("wvalid", 32'(M_AXI_WVALID), 32'(!w_seen));
      chk("bready", 32'(M_AXI_BREADY), 32'(aw_seen && w_seen && !b_done));
      if (b_done || c > 60) break;
      if (M_AXI_AWVALID) chk("awaddr", M_AXI_AWADDR, addr);
      if (M_AXI_WVALID) begin
        chk("wdata", M_AXI_WDATA, wdata);
        chk("wstrb", 32'(M_AXI_WSTRB), 32'(strb));
      end
      aw_hs = M_AXI_AWVALID && !aw_seen && (c >= aw_dly);
      w_hs  = M_AXI_WVALID && !w_seen && (c >= w_dly);
      if (aw_hs) cap_addr = M_AXI_AWADDR;
      if (w_hs) begin
        cap_data = M_AXI_WDATA;
        cap_strb = M_AXI_WSTRB;
      end
      M_AXI_AWREADY = aw_hs;
      M_AXI_WREADY  = w_hs;
      M_AXI_BVALID  = aw_seen && w_seen;
      M_AXI_BRESP   = bresp;
      b_hs = M_AXI_BVALID && M_AXI_BREADY;
      @(posedge clk);
      @(negedge clk);
      if (aw_hs) begin aw_seen = 1; aw_hs_c = c; end
      if (w_hs) begin w_seen = 1; w_hs_c = c; end
      if (b_hs) begin
        b_done = 1;
        for (int i = 0; i < 4; i++)
          if (cap_strb[i]) mem[cap_addr[5:2]][8*i +: 8] = cap_data[8*i +: 8];
      end
      c++;
    end
    M_AXI_AWREADY = 1'b0;
    M_AXI_WREADY  = 1'b0;
    M_AXI_BVALID  = 1'b0;
    M_AXI_BRESP   = 2'b00;
    chk("write_done_in_budget", 32'(b_done), 1);
  endtask

  // Slave read side: ARREADY after ar_dly cycles, RVALID r_dly cycles after the AR transfer.
  task automatic slave_read(input logic [31:0] addr, input int ar_dly, input int r_dly,
                            input logic [1:0] rresp);
    bit ar_seen, r_done, ar_hs, r_hs;
    int c, ar_c;
    ar_seen = 0; r_done = 0; c = 0; ar_c = 0;
    forever begin
      chk("arvalid", 32'(M_AXI_ARVALID), 32'(!ar_seen));
      chk("rready", 32'(M_AXI_RREADY), 32'(ar_seen && !r_done));
      if (r_done || c > 60) break;
      if (M_AXI_ARVALID) chk("araddr", M_AXI_ARADDR, addr);
      ar_hs = M_AXI_ARVALID && !ar_seen && (c >= ar_dly);
      M_AXI_ARREADY = ar_hs;
      M_AXI_RVALID  = ar_seen && (c >= ar_c + 1 + r_dly);
      M_AXI_RDATA   = M_AXI_RVALID ? mem[addr[5:2]] : 32'h0;
      M_AXI_RRESP   = M_AXI_RVALID ? rresp : 2'b00;
      r_hs = M_AXI_RVALID && M_AXI_RREADY;
      @(posedge clk);
      @(negedge clk);
      if (ar_hs) begin ar_seen = 1; ar_c = c; end
      if (r_hs) r_done = 1;
      c++;
    end
    M_AXI_ARREADY = 1'b0;
    M_AXI_RVALID  = 1'b0;
    M_AXI_RDATA   = '0;
    M_AXI_RRESP   = 2'b00;
    chk("read_done_in_budget", 32'(r_done), 1);
  endtask

  // Response consumer: holds rsp_ready low for 'hold' cycles, checking stability.
  task automatic wait_rsp(input logic [1:0] exp_resp, input logic [31:0] exp_rdata, input int hold);
    int n;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_valid", 32'(rsp_valid), 1);
    lat = cyc - acc_cyc;
    for (int i = 0; i <= hold; i++) begin
      chk("rsp_valid_held", 32'(rsp_valid), 1);
      chk("rsp_resp", 32'(rsp_resp), 32'(exp_resp));
      chk("rsp_rdata", rsp_rdata, exp_rdata);
      chk("cmd_ready_in_rsp", 32'(cmd_ready), 0);
      if (i < hold) @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_clear", 32'(rsp_valid), 0);
    chk("cmd_ready_idle", 32'(cmd_ready), 1);
  endtask

  initial begin
    ARESETN = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0;
    M_AXI_ARREADY = 1'b0; M_AXI_RDATA = '0; M_AXI_RRESP = '0; M_AXI_RVALID = 1'b0;
    M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BRESP = '0; M_AXI_BVALID = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;

    // Reset state
    #3;
    chk_all_zero("reset");
    repeat (2) @(negedge clk);
    ARESETN = 1'b1;
    #1;
    chk("post_reset_cmd_ready", 32'(cmd_ready), 1);
    chk("post_reset_state", 32'(dbg_state), 0);
    @(negedge clk);

    // Full write, AW and W accepted together
    send_cmd(1'b1, 32'h4, 32'hDEADBEEF, 4'hF);
    slave_write(32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 2'b00);
    chk("wr1_aw_cycle", 32'(aw_hs_c), 0);
    chk("wr1_w_cycle", 32'(w_hs_c), 0);
    wait_rsp(2'b00, 32'h0, 0);

    // Read-back against zero-wait slave: rsp_valid three cycles after accept
    send_cmd(1'b0, 32'h4, 32'h0, 4'h0);
    slave_read(32'h4, 0, 0, 2'b00);
    wait_rsp(2'b00, 32'hDEADBEEF, 0);
    chk("read_latency", 32'(lat), 3);

    // Partial strobe overwrite of the low half-word
    send_cmd(1'b1, 32'h4, 32'h11223344, 4'h3);
    slave_write(32'h4, 32'h11223344, 4'h3, 0, 0, 2'b00);
    wait_rsp(2'b00, 32'h0, 0);
    send_cmd(1'b0, 32'h4, 32'h0, 4'h0);
    slave_read(32'h4, 0, 0, 2'b00);
    wait_rsp(2'b00, 32'hDEAD3344, 0);

    // Skewed readies: AW three cycles ahead of W, then the reverse
    send_cmd(1'b1, 32'h8, 32'hA5A5A5A5, 4'hF);
    slave_write(32'h8, 32'hA5A5A5A5, 4'hF, 0, 3, 2'b00);
    chk("skew1_aw_cycle", 32'(aw_hs_c), 0);
    chk("skew1_w_cycle", 32'(w_hs_c), 3);
    wait_rsp(2'b00, 32'h0, 0);
    send_cmd(1'b1, 32'hC, 32'h5A5A5A5A, 4'hF);
    slave_write(32'hC, 32'h5A5A5A5A, 4'hF, 3, 0, 2'b00);
    chk("skew2_aw_cycle", 32'(aw_hs_c), 3);
    chk("skew2_w_cycle", 32'(w_hs_c), 0);
    wait_rsp(2'b00, 32'h0, 0);

    // SLVERR read held under five cycles of response back-pressure
    send_cmd(1'b0, 32'h8, 32'h0, 4'h0);
    slave_read(32'h8, 1, 2, 2'b10);
    wait_rsp(2'b10, 32'hA5A5A5A5, 5);

    // DECERR write response passes straight through
    send_cmd(1'b1, 32'h20, 32'h0BADF00D, 4'hF);
    slave_write(32'h20, 32'h0BADF00D, 4'hF, 1, 1, 2'b11);
    wait_rsp(2'b11, 32'h0, 0);

    // Reset while AWVALID is high: outputs clear without a clock edge
    send_cmd(1'b1, 32'h10, 32'h12345678, 4'hF);
    chk("pre_reset_awvalid", 32'(M_AXI_AWVALID), 1);
    #2;
    ARESETN = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    @(negedge clk);
    ARESETN = 1'b1;
    #1;
    chk("rearm_cmd_ready", 32'(cmd_ready), 1);
    @(negedge clk);
    send_cmd(1'b0, 32'hC, 32'h0, 4'h0);
    slave_read(32'hC, 2, 1, 2'b00);
    wait_rsp(2'b00, 32'h5A5A5A5A, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
